// File: rtl/ktane_i2c_pkg.sv
// Shared definitions for the button-module I2C target: FSM states, register
// indices and the register read-back mux.
package ktane_i2c_pkg;

    localparam int unsigned I2C_BITS = 8;
    localparam int unsigned CNT_W    = $clog2(I2C_BITS);

    localparam logic [1:0] REG_STRIP  = 2'd0;
    localparam logic [1:0] REG_COLOR  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } i2c_state_e;

    // Value presented on the bus when register idx is loaded into the TX shifter
    function automatic logic [I2C_BITS-1:0] read_reg(
        input logic [1:0]          idx,
        input logic [2:0]          strip,
        input logic [2:0]          color,
        input logic                btn,
        input logic                latch,
        input logic [I2C_BITS-1:0] id
    );
        logic [I2C_BITS-1:0] val;
        case (idx)
            REG_STRIP:  val = {5'd0, strip};
            REG_COLOR:  val = {5'd0, color};
            REG_STATUS: val = {6'd0, latch, btn};
            default:    val = id;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser plus history flop; emits single-cycle rise/fall pulses
// derived from the synchronised level.
module i2c_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic hist_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta_q <= RST_VAL;
            level  <= RST_VAL;
            hist_q <= RST_VAL;
        end else begin
            meta_q <= din;
            level  <= meta_q;
            hist_q <= level;
        end
    end

    assign rise_c = level & ~hist_q;
    assign fall_c = ~level & hist_q;

endmodule

// File: rtl/i2c_button_target.sv
// I2C target for the button satellite: 4-byte register map driving the strip
// and colour LEDs and reporting button state plus a fixed ID.
module i2c_button_target
    import ktane_i2c_pkg::*;
#(
    parameter logic [6:0]          ADDR = 7'h42,
    parameter logic [I2C_BITS-1:0] ID   = 8'hB7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic       button,
    output logic [2:0] led_strip,
    output logic [2:0] led_color,
    output logic       busy
);

    logic scl_lvl, scl_rise_c, scl_fall_c;
    logic sda_lvl, sda_rise_c, sda_fall_c;
    logic btn_lvl, btn_rise_c, btn_fall_unused;

    i2c_sync_edge #(.RST_VAL(1'b1)) u_scl_sync (
        .clock(clock), .reset(reset), .din(scl),
        .level(scl_lvl), .rise_c(scl_rise_c), .fall_c(scl_fall_c)
    );

    i2c_sync_edge #(.RST_VAL(1'b1)) u_sda_sync (
        .clock(clock), .reset(reset), .din(sda),
        .level(sda_lvl), .rise_c(sda_rise_c), .fall_c(sda_fall_c)
    );

    i2c_sync_edge #(.RST_VAL(1'b0)) u_btn_sync (
        .clock(clock), .reset(reset), .din(button),
        .level(btn_lvl), .rise_c(btn_rise_c), .fall_c(btn_fall_unused)
    );

    i2c_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [I2C_BITS-1:0] shift_q, shift_d;
    logic [I2C_BITS-1:0] tx_q, tx_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [2:0]          strip_d, color_d;
    logic                latch_q, latch_d;
    logic                rw_q, rw_d;
    logic                phase_q, phase_d;
    logic                sda_low_q, sda_low_d;
    logic                latch_clr_c;
    logic                start_c, stop_c;
    logic [I2C_BITS-1:0] byte_c;
    logic [I2C_BITS-1:0] rd_c;

    assign start_c = sda_fall_c & scl_lvl;
    assign stop_c  = sda_rise_c & scl_lvl;
    assign byte_c  = {shift_q[I2C_BITS-2:0], sda_lvl};
    assign rd_c    = read_reg(ptr_q, led_strip, led_color, btn_lvl, latch_q, ID);

    // Open-drain pad: only ever pull low or float
    assign sda = sda_low_q ? 1'b0 : 1'bz;

    // Next-state and datapath; phase_q marks the second half of an ACK slot
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        strip_d     = led_strip;
        color_d     = led_color;
        rw_d        = rw_q;
        phase_d     = phase_q;
        sda_low_d   = sda_low_q;
        latch_clr_c = 1'b0;

        if (start_c) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_low_d = 1'b0;
        end else if (stop_c) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise_c) begin
                        shift_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(I2C_BITS - 1)) begin
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            if (state_q == S_ADDR) begin
                                rw_d    = byte_c[0];
                                state_d = (byte_c[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
                            end else if (state_q == S_PTR) begin
                                ptr_d   = byte_c[1:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                if (ptr_q == REG_STRIP) strip_d = byte_c[2:0];
                                if (ptr_q == REG_COLOR) color_d = byte_c[2:0];
                                ptr_d   = ptr_q + 2'd1;
                                state_d = S_WDATA_ACK;
                            end
                        end
                    end
                end

                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall_c) begin
                        if (!phase_q) begin
                            phase_d   = 1'b1;
                            sda_low_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            sda_low_d = 1'b0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d     = S_RDATA;
                                tx_d        = rd_c;
                                sda_low_d   = ~rd_c[I2C_BITS-1];
                                latch_clr_c = (ptr_q == REG_STATUS);
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    if (scl_rise_c) begin
                        tx_d      = tx_q << 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(I2C_BITS - 1)) begin
                            bit_cnt_d = '0;
                            ptr_d     = ptr_q + 2'd1;
                            phase_d   = 1'b0;
                            state_d   = S_RDATA_ACK;
                        end
                    end else if (scl_fall_c) begin
                        sda_low_d = ~tx_q[I2C_BITS-1];
                    end
                end

                // Release after the last bit, sample controller ACK, then resume
                S_RDATA_ACK: begin
                    if (scl_rise_c) begin
                        if (!sda_lvl) begin
                            phase_d     = 1'b1;
                            tx_d        = rd_c;
                            latch_clr_c = (ptr_q == REG_STATUS);
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall_c) begin
                        if (phase_q) begin
                            phase_d   = 1'b0;
                            state_d   = S_RDATA;
                            sda_low_d = ~tx_q[I2C_BITS-1];
                        end else begin
                            sda_low_d = 1'b0;
                        end
                    end
                end

                default: ;
            endcase
        end

        latch_d = btn_rise_c | (latch_q & ~latch_clr_c);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            led_strip <= '0;
            led_color <= '0;
            latch_q   <= 1'b0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            sda_low_q <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            led_strip <= strip_d;
            led_color <= color_d;
            latch_q   <= latch_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            sda_low_q <= sda_low_d;
            busy      <= (state_d != S_IDLE) && (state_d != S_IGNORE);
        end
    end

endmodule

// File: tb/tb_i2c_button_target.sv
// Directed bench for i2c_button_target: a bit-banged controller drives the bus
// and every response is compared against hand-computed values.
module tb_i2c_button_target;

    localparam int Q = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       scl;
    logic       button;
    logic       ctrl_low;
    wire        sda;
    logic [2:0] led_strip;
    logic [2:0] led_color;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    assign sda = ctrl_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_button_target dut (
        .clock(clock), .reset(reset), .scl(scl), .sda(sda), .button(button),
        .led_strip(led_strip), .led_color(led_color), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [2:0] strip;
        logic [2:0] color;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        ctrl_low = 1'b0; hold(Q);
        scl = 1'b1;      hold(Q);
        ctrl_low = 1'b1; hold(Q);
        scl = 1'b0;      hold(Q);
    endtask

    task automatic i2c_stop();
        ctrl_low = 1'b1; hold(Q);
        scl = 1'b1;      hold(Q);
        ctrl_low = 1'b0; hold(Q);
    endtask

    task automatic put_bit(input logic b);
        ctrl_low = ~b; hold(Q);
        scl = 1'b1;    hold(2 * Q);
        scl = 1'b0;    hold(Q);
    endtask

    task automatic get_bit(output logic b);
        ctrl_low = 1'b0; hold(Q);
        scl = 1'b1;      hold(Q);
        b = sda;         hold(Q);
        scl = 1'b0;      hold(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
    endtask

    task automatic get_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    // Set pointer and write one or two data bytes; returns the number of ACKs seen
    task automatic wr(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                      input bit two, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        put_byte(8'h84, a); acks += int'(a);
        put_byte(p, a);     acks += int'(a);
        put_byte(d0, a);    acks += int'(a);
        if (two) begin
            put_byte(d1, a); acks += int'(a);
        end
        i2c_stop();
    endtask

    // Set pointer, repeated START, read one byte with NACK
    task automatic rd(input logic [7:0] p, output logic [7:0] d, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        put_byte(8'h84, a); acks += int'(a);
        put_byte(p, a);     acks += int'(a);
        i2c_start();
        put_byte(8'h85, a); acks += int'(a);
        get_byte(1'b0, d);
        i2c_stop();
    endtask

    initial begin
        vec_t       vecs[6];
        logic       a;
        logic [7:0] d0, d1;
        int         acks;

        vecs[0] = '{idx: 8'h00, wdata: 8'h05, rdata: 8'h05, strip: 3'd5, color: 3'd0};
        vecs[1] = '{idx: 8'h01, wdata: 8'hFB, rdata: 8'h03, strip: 3'd5, color: 3'd3};
        vecs[2] = '{idx: 8'hFC, wdata: 8'hFA, rdata: 8'h02, strip: 3'd2, color: 3'd3};
        vecs[3] = '{idx: 8'h03, wdata: 8'hFF, rdata: 8'hB7, strip: 3'd2, color: 3'd3};
        vecs[4] = '{idx: 8'h02, wdata: 8'h55, rdata: 8'h00, strip: 3'd2, color: 3'd3};
        vecs[5] = '{idx: 8'h01, wdata: 8'h07, rdata: 8'h07, strip: 3'd2, color: 3'd7};

        reset = 1'b0; scl = 1'b1; ctrl_low = 1'b0; button = 1'b0;
        hold(4);
        check("reset_sda", 32'(sda), 32'd1);
        check("reset_strip", 32'(led_strip), 32'd0);
        check("reset_color", 32'(led_color), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        hold(4);

        // Register map walk; idx 0xFC exercises upper pointer bits being ignored
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].idx, vecs[i].wdata, 8'h00, 1'b0, acks);
            check($sformatf("vec%0d_wr_acks", i), 32'(acks), 32'd3);
            check($sformatf("vec%0d_strip", i), 32'(led_strip), 32'(vecs[i].strip));
            check($sformatf("vec%0d_color", i), 32'(led_color), 32'(vecs[i].color));
            rd(vecs[i].idx, d0, acks);
            check($sformatf("vec%0d_rd_acks", i), 32'(acks), 32'd3);
            check($sformatf("vec%0d_rdata", i), 32'(d0), 32'(vecs[i].rdata));
            check($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'd0);
        end

        // Auto-increment write, then read with no pointer byte shows ptr = 2
        i2c_start();
        put_byte(8'h84, a); check("seq_addr_ack", 32'(a), 32'd1);
        check("seq_busy", 32'(busy), 32'd1);
        put_byte(8'h00, a); check("seq_ptr_ack", 32'(a), 32'd1);
        put_byte(8'h05, a); check("seq_d0_ack", 32'(a), 32'd1);
        put_byte(8'h03, a); check("seq_d1_ack", 32'(a), 32'd1);
        i2c_stop();
        hold(4);
        check("seq_strip", 32'(led_strip), 32'd5);
        check("seq_color", 32'(led_color), 32'd3);
        check("seq_busy_after_stop", 32'(busy), 32'd0);
        i2c_start();
        put_byte(8'h85, a); check("ptr2_addr_ack", 32'(a), 32'd1);
        get_byte(1'b0, d0);
        i2c_stop();
        check("ptr2_status", 32'(d0), 32'h00);

        // Pointer 3, repeated START, two-byte read wrapping to reg 0
        i2c_start();
        put_byte(8'h84, a);
        put_byte(8'h03, a);
        i2c_start();
        put_byte(8'h85, a); check("rs_addr_ack", 32'(a), 32'd1);
        get_byte(1'b1, d0);
        get_byte(1'b0, d1);
        hold(2);
        check("rs_byte0", 32'(d0), 32'hB7);
        check("rs_byte1", 32'(d1), 32'h05);
        check("rs_sda_released", 32'(sda), 32'd1);
        check("rs_busy_after_nack", 32'(busy), 32'd0);
        i2c_stop();

        // Foreign address is ignored
        i2c_start();
        put_byte(8'hA0, a); check("foreign_no_ack", 32'(a), 32'd0);
        check("foreign_busy", 32'(busy), 32'd0);
        put_byte(8'h00, a); check("foreign_ptr_no_ack", 32'(a), 32'd0);
        put_byte(8'h07, a);
        i2c_stop();
        check("foreign_strip", 32'(led_strip), 32'd5);
        check("foreign_color", 32'(led_color), 32'd3);
        wr(8'h01, 8'h06, 8'h00, 1'b0, acks);
        check("post_foreign_acks", 32'(acks), 32'd3);
        check("post_foreign_color", 32'(led_color), 32'd6);

        // Press latch: released press, then held press
        button = 1'b1; hold(10); button = 1'b0; hold(10);
        rd(8'h02, d0, acks); check("btn_rel_first", 32'(d0), 32'h02);
        rd(8'h02, d0, acks); check("btn_rel_second", 32'(d0), 32'h00);
        button = 1'b1; hold(10);
        rd(8'h02, d0, acks); check("btn_held_first", 32'(d0), 32'h03);
        rd(8'h02, d0, acks); check("btn_held_second", 32'(d0), 32'h01);
        button = 1'b0; hold(10);

        // Write to ID register is discarded, pointer wraps to reg 0
        wr(8'h03, 8'hFF, 8'h04, 1'b1, acks);
        check("wrap_acks", 32'(acks), 32'd4);
        check("wrap_strip", 32'(led_strip), 32'd4);
        rd(8'h03, d0, acks); check("id_after_write", 32'(d0), 32'hB7);

        // Reset while the target is holding the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) put_bit(1'((8'h84 >> i) & 8'h01));
        ctrl_low = 1'b0; hold(Q);
        scl = 1'b1; hold(Q);
        check("ack_driven", 32'(sda), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("reset_mid_sda", 32'(sda), 32'd1);
        hold(2);
        check("reset_mid_strip", 32'(led_strip), 32'd0);
        check("reset_mid_color", 32'(led_color), 32'd0);
        check("reset_mid_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        hold(2);
        scl = 1'b0; hold(Q);
        i2c_stop();
        i2c_start();
        put_byte(8'h85, a); check("recover_addr_ack", 32'(a), 32'd1);
        get_byte(1'b0, d0);
        i2c_stop();
        check("recover_read", 32'(d0), 32'h00);
        wr(8'h00, 8'h01, 8'h00, 1'b0, acks);
        check("recover_acks", 32'(acks), 32'd3);
        check("recover_strip", 32'(led_strip), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
